// File: rtl/clk_period_meter.sv
// Measures high time, low time and period of a slow input in system clock cycles.
// Each completed rise-to-rise period produces one meas_valid strobe; a phase that overflows sets timeout.
module clk_period_meter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          sig_in,
  output logic [CW-1:0] high_time,
  output logic [CW-1:0] low_time,
  output logic [CW:0]   period,
  output logic          meas_valid,
  output logic          timeout
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MEAS_HIGH = 2'd1,
    ST_MEAS_LOW  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic          r_s1, r_s2, r_prev;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_hi_cnt, w_hi_nxt;
  logic [CW-1:0] r_lo_cnt, w_lo_nxt;
  logic [CW-1:0] r_high_time, w_high_nxt;
  logic [CW-1:0] r_low_time, w_low_nxt;
  logic [CW:0]   r_period, w_period_nxt;
  logic          r_meas_valid, w_valid_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic          w_rise, w_fall;

  assign w_rise = r_s2 & ~r_prev;
  assign w_fall = ~r_s2 & r_prev;

  // Two-stage synchroniser for the asynchronous input plus edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= sig_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // State, phase counters and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_hi_cnt     <= CNT_ZERO;
      r_lo_cnt     <= CNT_ZERO;
      r_high_time  <= CNT_ZERO;
      r_low_time   <= CNT_ZERO;
      r_period     <= {(CW+1){1'b0}};
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hi_cnt     <= w_hi_nxt;
      r_lo_cnt     <= w_lo_nxt;
      r_high_time  <= w_high_nxt;
      r_low_time   <= w_low_nxt;
      r_period     <= w_period_nxt;
      r_meas_valid <= w_valid_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  // Next-state and next-result logic; results only change on a completed period
  always_comb begin
    w_state_nxt   = r_state;
    w_hi_nxt      = r_hi_cnt;
    w_lo_nxt      = r_lo_cnt;
    w_high_nxt    = r_high_time;
    w_low_nxt     = r_low_time;
    w_period_nxt  = r_period;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = r_timeout;

    if (!en) begin
      w_state_nxt   = ST_IDLE;
      w_hi_nxt      = CNT_ZERO;
      w_lo_nxt      = CNT_ZERO;
      w_timeout_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_lo_nxt = CNT_ZERO;
          if (w_rise) begin
            w_state_nxt = ST_MEAS_HIGH;
            w_hi_nxt    = CNT_ONE;
          end else begin
            w_state_nxt = ST_IDLE;
            w_hi_nxt    = CNT_ZERO;
          end
        end
        ST_MEAS_HIGH: begin
          if (w_fall) begin
            w_state_nxt = ST_MEAS_LOW;
            w_lo_nxt    = CNT_ONE;
          end else if (r_s2) begin
            if (r_hi_cnt == CNT_MAX) begin
              w_state_nxt   = ST_IDLE;
              w_hi_nxt      = CNT_ZERO;
              w_lo_nxt      = CNT_ZERO;
              w_timeout_nxt = 1'b1;
            end else begin
              w_hi_nxt = r_hi_cnt + CNT_ONE;
            end
          end else begin
            w_state_nxt = ST_MEAS_HIGH;
          end
        end
        ST_MEAS_LOW: begin
          if (w_rise) begin
            w_high_nxt    = r_hi_cnt;
            w_low_nxt     = r_lo_cnt;
            w_period_nxt  = {1'b0, r_hi_cnt} + {1'b0, r_lo_cnt};
            w_valid_nxt   = 1'b1;
            w_timeout_nxt = 1'b0;
            w_hi_nxt      = CNT_ONE;
            w_lo_nxt      = CNT_ZERO;
            w_state_nxt   = ST_MEAS_HIGH;
          end else if (!r_s2) begin
            if (r_lo_cnt == CNT_MAX) begin
              w_state_nxt   = ST_IDLE;
              w_hi_nxt      = CNT_ZERO;
              w_lo_nxt      = CNT_ZERO;
              w_timeout_nxt = 1'b1;
            end else begin
              w_lo_nxt = r_lo_cnt + CNT_ONE;
            end
          end else begin
            w_state_nxt = ST_MEAS_LOW;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_hi_nxt    = CNT_ZERO;
          w_lo_nxt    = CNT_ZERO;
        end
      endcase
    end
  end

  assign high_time  = r_high_time;
  assign low_time   = r_low_time;
  assign period     = r_period;
  assign meas_valid = r_meas_valid;
  assign timeout    = r_timeout;

endmodule
